// File: rtl/servo_pkg.sv
// Shared constants, state encoding and clamp helper for the servo pulse-width path.
package servo_pkg;

   localparam int SERVO_CLK_F    = 50;
   localparam int SERVO_FRAME_US = 20000;
   localparam int SERVO_MIN_LEN  = 500;
   localparam int SERVO_MAX_LEN  = 2500;
   localparam int SERVO_CENTRE   = 1500;

   typedef enum logic {
      IDLE = 1'b0,
      MOVE = 1'b1
   } servo_state_t;

   function automatic logic [15:0] servo_clamp(input logic [15:0] len,
                                               input logic [15:0] lo,
                                               input logic [15:0] hi);
      if (len < lo)
         return lo;
      else if (len > hi)
         return hi;
      else
         return len;
   endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// Frame timer: a 1 us prescaler feeding a per-frame microsecond counter.
// It emits a registered one-cycle frame_tick at each frame boundary.
module servo_frame_timer
   import servo_pkg::*;
#(
   parameter int CLK_F    = SERVO_CLK_F,
   parameter int FRAME_US = SERVO_FRAME_US
) (
   input  logic CLK,
   input  logic RST_N,
   output logic frame_tick
);

   localparam int PW = (CLK_F > 1) ? $clog2(CLK_F) : 1;
   localparam int UW = (FRAME_US > 1) ? $clog2(FRAME_US) : 1;

   logic [PW-1:0] presc_reg;
   logic [UW-1:0] us_reg;
   logic          tick_reg;
   logic          presc_wrap;
   logic          us_wrap;

   assign presc_wrap = (presc_reg == PW'(CLK_F - 1));
   assign us_wrap    = (us_reg == UW'(FRAME_US - 1));
   assign frame_tick = tick_reg;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         presc_reg <= '0;
         us_reg    <= '0;
         tick_reg  <= 1'b0;
      end else begin
         presc_reg <= presc_wrap ? '0 : presc_reg + PW'(1);
         if (presc_wrap)
            us_reg <= us_wrap ? '0 : us_reg + UW'(1);
         tick_reg <= presc_wrap & us_wrap;
      end
   end

endmodule

// File: rtl/servo_ramp.sv
// Target acceptance, clamping and once-per-frame slew of the servo pulse width.
// pul_len only moves on frame_tick edges, so the PWM stage never sees a jerk.
module servo_ramp
   import servo_pkg::*;
#(
   parameter int CLK_F    = SERVO_CLK_F,
   parameter int FRAME_US = SERVO_FRAME_US,
   parameter int MIN_LEN  = SERVO_MIN_LEN,
   parameter int MAX_LEN  = SERVO_MAX_LEN,
   parameter int INIT_LEN = SERVO_CENTRE
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic [15:0] tgt_len,
   input  logic        tgt_valid,
   output logic        tgt_ready,
   input  logic [7:0]  step_len,
   output logic [15:0] pul_len,
   output logic        busy,
   output logic        done,
   output logic        frame_tick
);

   localparam logic [15:0] MIN_L  = 16'(MIN_LEN);
   localparam logic [15:0] MAX_L  = 16'(MAX_LEN);
   localparam logic [15:0] INIT_L = 16'(INIT_LEN);

   servo_state_t state_reg, state_next;
   logic [15:0]  pul_reg, pul_next;
   logic [15:0]  tgt_reg, tgt_next;
   logic         done_reg, done_next;
   logic         ready_reg;

   logic         accept;
   logic [15:0]  clamped_len;
   logic [15:0]  step_val;
   logic [16:0]  pul_w, tgt_w, stp_w, up_sum, dn_lim;

   servo_frame_timer #(
      .CLK_F    (CLK_F),
      .FRAME_US (FRAME_US)
   ) u_timer (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .frame_tick (frame_tick)
   );

   assign accept      = tgt_valid & ready_reg;
   assign clamped_len = servo_clamp(tgt_len, MIN_L, MAX_L);

   // 17-bit operands so neither the up-sum nor the down limit can wrap.
   assign pul_w  = {1'b0, pul_reg};
   assign tgt_w  = {1'b0, tgt_reg};
   assign stp_w  = {9'd0, step_len};
   assign up_sum = pul_w + stp_w;
   assign dn_lim = tgt_w + stp_w;

   always_comb begin
      step_val = tgt_reg;
      if (step_len != 8'd0) begin
         if (tgt_reg > pul_reg) begin
            if (up_sum < tgt_w)
               step_val = up_sum[15:0];
         end else if (pul_w > dn_lim) begin
            step_val = pul_reg - 16'(step_len);
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      pul_next   = pul_reg;
      tgt_next   = tgt_reg;
      done_next  = 1'b0;
      if (accept)
         tgt_next = clamped_len;
      case (state_reg)
         IDLE: begin
            if (accept && (clamped_len != pul_reg))
               state_next = MOVE;
         end
         MOVE: begin
            // A retarget on the step edge keeps us moving; the next tick settles it.
            if (frame_tick) begin
               pul_next = step_val;
               if ((step_val == tgt_reg) && !accept) begin
                  state_next = IDLE;
                  done_next  = 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_reg <= IDLE;
         pul_reg   <= INIT_L;
         tgt_reg   <= INIT_L;
         done_reg  <= 1'b0;
         ready_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         pul_reg   <= pul_next;
         tgt_reg   <= tgt_next;
         done_reg  <= done_next;
         ready_reg <= 1'b1;
      end
   end

   assign tgt_ready = ready_reg;
   assign pul_len   = pul_reg;
   assign busy      = (state_reg == MOVE);
   assign done      = done_reg;

endmodule

// File: tb/tb_servo_ramp.sv
// Directed bench for servo_ramp with a 20-cycle frame (CLK_F=2, FRAME_US=10).
`timescale 1ns/1ps
module tb_servo_ramp;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic [15:0] tgt_len;
   logic        tgt_valid;
   logic        tgt_ready;
   logic [7:0]  step_len;
   logic [15:0] pul_len;
   logic        busy;
   logic        done;
   logic        frame_tick;

   always #5 CLK = ~CLK;

   servo_ramp #(
      .CLK_F    (2),
      .FRAME_US (10)
   ) dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .tgt_len    (tgt_len),
      .tgt_valid  (tgt_valid),
      .tgt_ready  (tgt_ready),
      .step_len   (step_len),
      .pul_len    (pul_len),
      .busy       (busy),
      .done       (done),
      .frame_tick (frame_tick)
   );

   typedef struct {
      int len;
      int stp;
      int exp_first;
      int exp_last;
      int exp_steps;
   } vec_t;

   vec_t vt[11];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   seen_q[$];
   int   n_done;
   int   n_offtick;
   int   timed_out;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end else begin
         $display("ok   %s = %0d", name, act);
      end
   endtask

   // Present one target on a non-tick edge so the accept never coincides with a step.
   task automatic send(input int len, input int stp);
      for (int k = 0; k < 4; k++) begin
         @(negedge CLK);
         if (!frame_tick) break;
      end
      tgt_len   = 16'(len);
      step_len  = 8'(stp);
      tgt_valid = 1'b1;
      @(negedge CLK);
      tgt_valid = 1'b0;
   endtask

   task automatic collect(input bit idle_exit, input int limit);
      int prev;
      int prev_tick;
      seen_q.delete();
      n_done    = 0;
      n_offtick = 0;
      timed_out = idle_exit ? 1 : 0;
      prev      = int'(pul_len);
      prev_tick = int'(frame_tick);
      for (int c = 0; c < limit; c++) begin
         @(negedge CLK);
         if (int'(pul_len) != prev) begin
            seen_q.push_back(int'(pul_len));
            if (prev_tick == 0) n_offtick++;
         end
         if (done) n_done++;
         prev      = int'(pul_len);
         prev_tick = int'(frame_tick);
         if (idle_exit && !busy) begin
            timed_out = 0;
            repeat (2) begin
               @(negedge CLK);
               if (done) n_done++;
            end
            break;
         end
      end
   endtask

   task automatic wait_val(input int v, input string name);
      for (int c = 0; c < 100; c++) begin
         if (int'(pul_len) == v) break;
         @(negedge CLK);
      end
      check(name, int'(pul_len), v);
   endtask

   task automatic wait_tick(input string name);
      int seen;
      seen = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge CLK);
         if (frame_tick) begin
            seen = 1;
            break;
         end
      end
      check(name, seen, 1);
   endtask

   task automatic count_to_tick(input int start, input string name, input int exp);
      int cnt;
      cnt = start;
      for (int c = 0; c < 60; c++) begin
         @(negedge CLK);
         cnt++;
         if (frame_tick) break;
      end
      check(name, cnt, exp);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_seq[5];
      vt[0]  = '{1600,  30, 1430, 1600, 7};
      vt[1]  = '{3000, 200, 1800, 2500, 5};
      vt[2]  = '{100,    0,  500,  500, 1};
      vt[3]  = '{510,    7,  507,  510, 2};
      vt[4]  = '{2000, 255,  765, 2000, 6};
      vt[5]  = '{1990,  20, 1990, 1990, 1};
      vt[6]  = '{499,    0,  500,  500, 1};
      vt[7]  = '{0,      5,  500,  500, 0};
      vt[8]  = '{2500,   0, 2500, 2500, 1};
      vt[9]  = '{65535, 10, 2500, 2500, 0};
      vt[10] = '{500,  255, 2245,  500, 8};

      // Reset state and timer phase
      tgt_len   = 16'd0;
      step_len  = 8'd0;
      tgt_valid = 1'b0;
      RST_N     = 1'b1;
      #1 RST_N  = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      check("rst_pul", int'(pul_len), 1500);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_tick", int'(frame_tick), 0);
      check("rst_ready", int'(tgt_ready), 0);
      RST_N = 1'b1;
      @(negedge CLK);
      check("ready_after_rel", int'(tgt_ready), 1);
      count_to_tick(1, "first_tick_cycles", 20);
      @(negedge CLK);
      check("tick_width", int'(frame_tick), 0);
      count_to_tick(1, "tick_period", 20);
      check("idle_pul", int'(pul_len), 1500);
      check("idle_busy", int'(busy), 0);

      // Mid-move retarget downward
      send(1600, 30);
      wait_val(1530, "b_first_step");
      send(1400, 30);
      collect(1'b1, 400);
      exp_seq = '{1500, 1470, 1440, 1410, 1400};
      check("b_nsteps", seen_q.size(), 5);
      for (int k = 0; k < 5; k++)
         check($sformatf("b_step%0d", k), (k < seen_q.size()) ? seen_q[k] : -1, exp_seq[k]);
      check("b_done", n_done, 1);
      check("b_timeout", timed_out, 0);

      // Table of single moves
      for (int i = 0; i < 11; i++) begin
         send(vt[i].len, vt[i].stp);
         check($sformatf("v%0d_busy", i), int'(busy), (vt[i].exp_steps > 0) ? 1 : 0);
         collect(vt[i].exp_steps > 0, (vt[i].exp_steps > 0) ? 400 : 25);
         check($sformatf("v%0d_steps", i), seen_q.size(), vt[i].exp_steps);
         check($sformatf("v%0d_first", i),
               (seen_q.size() > 0) ? seen_q[0] : int'(pul_len), vt[i].exp_first);
         check($sformatf("v%0d_last", i), int'(pul_len), vt[i].exp_last);
         check($sformatf("v%0d_done", i), n_done, (vt[i].exp_steps > 0) ? 1 : 0);
         check($sformatf("v%0d_offtick", i), n_offtick, 0);
         check($sformatf("v%0d_timeout", i), timed_out, 0);
      end

      // Accept on the same edge as a tick steps toward the old target
      send(900, 100);
      wait_val(600, "c_first_step");
      wait_tick("c_tick_seen");
      tgt_len   = 16'd520;
      tgt_valid = 1'b1;
      @(negedge CLK);
      tgt_valid = 1'b0;
      check("c_coincident_step", int'(pul_len), 700);
      check("c_busy", int'(busy), 1);
      collect(1'b1, 400);
      check("c_nsteps", seen_q.size(), 2);
      check("c_step0", (seen_q.size() > 0) ? seen_q[0] : -1, 600);
      check("c_step1", (seen_q.size() > 1) ? seen_q[1] : -1, 520);
      check("c_done", n_done, 1);

      // Retarget to the current width while moving: done on the next tick
      send(820, 100);
      wait_val(620, "d_first_step");
      send(620, 100);
      check("d_busy_hold", int'(busy), 1);
      check("d_no_early_done", int'(done), 0);
      wait_tick("d_tick_seen");
      @(negedge CLK);
      check("d_pul", int'(pul_len), 620);
      check("d_busy_clear", int'(busy), 0);
      check("d_done", int'(done), 1);
      @(negedge CLK);
      check("d_done_clear", int'(done), 0);

      // Asynchronous reset in the middle of a move
      send(1000, 100);
      wait_val(720, "e_first_step");
      repeat (3) @(negedge CLK);
      #2 RST_N = 1'b0;
      #1;
      check("e_rst_pul", int'(pul_len), 1500);
      check("e_rst_busy", int'(busy), 0);
      check("e_rst_ready", int'(tgt_ready), 0);
      check("e_rst_tick", int'(frame_tick), 0);
      check("e_rst_done", int'(done), 0);
      @(negedge CLK);
      @(negedge CLK);
      RST_N = 1'b1;
      count_to_tick(0, "e_first_tick_cycles", 20);
      @(negedge CLK);
      check("e_pul_after_tick", int'(pul_len), 1500);
      check("e_busy_after_tick", int'(busy), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
